rr_tag_arbiter: RTL and testbench
=================================

RR_TAG_ARBITER -- requirements
Module: rr_tag_arbiter

Interface
REQ-001 Parameter nbits, default 32: payload width of each input stream.
REQ-002 Parameter num_inputs, default 16: number of input streams, power of two, 2..16.
REQ-003 Derived constant AW = $clog2(num_inputs): width of the source-address tag.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port recv_val[0:num_inputs-1], input, 1 each: input i presents a packet.
REQ-007 Port recv_rdy[0:num_inputs-1], output, 1 each: input i's packet is consumed this cycle.
REQ-008 Port recv_msg[0:num_inputs-1], input, nbits each: payload of input i.
REQ-009 Port send_val, output, 1: output buffer holds a packet.
REQ-010 Port send_rdy, input, 1: downstream accepts the packet.
REQ-011 Port send_msg, output, nbits+AW: {source index (AW MSBs), payload (nbits LSBs)}.

Function
REQ-012 Transfers SHALL occur only on cycles where val and rdy are both high, on both sides.
REQ-013 The block SHALL hold a one-entry output register; send_val, send_msg SHALL be registered outputs.
REQ-014 Accept condition SHALL be: !send_val | send_rdy (empty, or draining this cycle).
REQ-015 When accept holds and any recv_val is high, the grant g SHALL be the first asserted index at or after ptr, searching upward and wrapping from num_inputs-1 to 0.
REQ-016 recv_rdy SHALL be combinational; only recv_rdy[g] is high, and only on a granting cycle. All other recv_rdy SHALL be low.
REQ-017 On a grant, the next cycle SHALL show send_val=1 and send_msg={g[AW-1:0], recv_msg[g]}. Latency is 1 cycle.
REQ-018 On a grant, ptr SHALL become (g+1) mod num_inputs.
REQ-019 With no grant, ptr SHALL hold its value.
REQ-020 With send_val=1 and send_rdy=0, the output register and ptr SHALL hold, and all recv_rdy SHALL be 0.
REQ-021 Simultaneous drain and grant SHALL sustain 1 packet/cycle with no bubble.
REQ-022 Drain with no requester SHALL clear send_val next cycle.
REQ-023 recv_rdy SHALL NOT depend combinationally on recv_msg.
REQ-024 recv_rdy MAY depend combinationally on send_rdy and recv_val.
REQ-025 Round-robin fairness: a continuously valid input SHALL be granted within num_inputs grants.

Reset
REQ-026 Reset SHALL asynchronously set send_val=0, send_msg=0 and ptr=0.
REQ-027 A buffered packet present when reset asserts SHALL be discarded.
REQ-028 recv_rdy SHALL be all-zero while reset is high.

Configuration
REQ-029 Macro RR_TAG_ARB_PRIO0_EN: when defined, input 0 SHALL have strict priority over all others whenever recv_val[0] is high. A grant to input 0 SHALL NOT modify ptr. Inputs 1..num_inputs-1 SHALL round-robin as in REQ-015/018.
REQ-030 Without RR_TAG_ARB_PRIO0_EN, all inputs SHALL be pure round-robin per REQ-015.

Structure
REQ-031 Package rr_tag_arb_pkg SHALL hold the default NBITS/NUM_INPUTS constants and the tagged-packet typedef helper (address field plus payload field).
REQ-032 Sub-module rr_tag_arb_picker SHALL hold the combinational wrap-around priority search. Inputs: request vector and ptr. Outputs: one-hot grant, encoded index, any.

Verification
REQ-033 Single source: recv_val[5]=1, msg 0x0000_ABCD, send_rdy=1 -> next cycle send_msg=0x5_0000ABCD, send_val=1, ptr=6.
REQ-034 All 16 sources continuously valid, send_rdy=1 -> output tags 0,1,2,...,15,0 on consecutive cycles, no bubbles.
REQ-035 Backpressure: output full with send_rdy=0 for 3 cycles while sources 2 and 9 are valid -> recv_rdy all 0 and send_msg stable for those cycles; after send_rdy=1, source 2 is granted, then 9.
REQ-036 Wrap: ptr=15, sources 3 and 14 valid -> grant 3, then 14.
REQ-037 Reset mid-operation: assert reset with send_val=1 -> send_val=0 immediately, and the first grant after reset is searched from index 0.
REQ-038 RR_TAG_ARB_PRIO0_EN defined, sources 0 and 4 continuously valid -> only tag 0 is output until recv_val[0] drops; then tag 4.

Source files
------------

// File: rtl/rr_tag_arb_pkg.sv
// rr_tag_arb_pkg: default sizes and tagged-packet layout for rr_tag_arbiter
package rr_tag_arb_pkg;
   localparam int NBITS = 32;
   localparam int NUM_INPUTS = 16;
   localparam int AW_DEF = $clog2(NUM_INPUTS);
   typedef struct packed {
      logic [AW_DEF-1:0] addr;
      logic [NBITS-1:0]  payload;
   } tag_pkt_t;
endpackage

// File: rtl/rr_tag_arb_picker.sv
// rr_tag_arb_picker: wrap-around priority search starting at ptr
module rr_tag_arb_picker #(
   parameter int n  = 16,
   parameter int aw = 4
) (
   input  logic [n-1:0]  req,
   input  logic [aw-1:0] ptr,
   output logic [n-1:0]  grant,
   output logic [aw-1:0] idx,
   output logic          any
);
   logic [aw-1:0] k;
   // scan offsets high to low so the nearest requester at or after ptr wins
   always_comb begin
      k = '0;
      idx = '0;
      for (int i = n - 1; i >= 0; i--) begin
         k = ptr + aw'(i);
         if (req[k]) idx = k;
      end
      any = |req;
      grant = any ? (n'(1) << idx) : '0;
   end
endmodule

// File: rtl/rr_tag_arbiter.sv
// rr_tag_arbiter: round-robin N:1 arbiter with source tag; RR_TAG_ARB_PRIO0_EN gives input 0 strict priority
module rr_tag_arbiter
   import rr_tag_arb_pkg::*;
#(
   parameter int nbits      = NBITS,
   parameter int num_inputs = NUM_INPUTS
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 recv_val [0:num_inputs-1],
   output logic                                 recv_rdy [0:num_inputs-1],
   input  logic [nbits-1:0]                     recv_msg [0:num_inputs-1],
   output logic                                 send_val,
   input  logic                                 send_rdy,
   output logic [nbits+$clog2(num_inputs)-1:0]  send_msg
);
   localparam int AW = $clog2(num_inputs);
   logic [num_inputs-1:0] req, req_pick, pick_oh, onehot;
   logic [AW-1:0] ptr, pick_idx, g;
   logic pick_any, gnt_any, upd_ptr, accept, grant_en;
   // flatten the per-input valids into a request vector
   always_comb for (int i = 0; i < num_inputs; i++) req[i] = recv_val[i];
`ifdef RR_TAG_ARB_PRIO0_EN
   assign req_pick = req & ~num_inputs'(1);
   assign onehot   = req[0] ? num_inputs'(1) : pick_oh;
   assign g        = req[0] ? '0 : pick_idx;
   assign gnt_any  = req[0] | pick_any;
   assign upd_ptr  = !req[0];
`else
   assign req_pick = req;
   assign onehot   = pick_oh;
   assign g        = pick_idx;
   assign gnt_any  = pick_any;
   assign upd_ptr  = 1'b1;
`endif
   rr_tag_arb_picker #(.n(num_inputs), .aw(AW)) u_pick (
      .req   (req_pick),
      .ptr   (ptr),
      .grant (pick_oh),
      .idx   (pick_idx),
      .any   (pick_any)
   );
   assign accept   = !send_val | send_rdy;
   assign grant_en = accept & gnt_any & !reset;
   // ready only to the granted input; independent of payload
   always_comb for (int i = 0; i < num_inputs; i++) recv_rdy[i] = grant_en & onehot[i];
   // one-entry output buffer and round-robin pointer
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         send_val <= 1'b0;
         send_msg <= '0;
         ptr      <= '0;
      end else if (accept) begin
         send_val <= gnt_any;
         if (gnt_any) send_msg <= {g, recv_msg[g]};
         if (gnt_any && upd_ptr) ptr <= g + AW'(1);
      end
   end
endmodule

// File: tb/tb_rr_tag_arbiter.sv
// tb_rr_tag_arbiter: directed vector bench for rr_tag_arbiter
module tb_rr_tag_arbiter;
   import rr_tag_arb_pkg::*;
   typedef struct {
      logic [15:0] val;
      logic        srdy;
      logic [15:0] rdy;
      logic        sval;
      logic [3:0]  tag;
   } vec_t;
   logic clk = 1'b0, reset = 1'b1, send_rdy = 1'b1, send_val;
   logic [15:0] val_v = 16'hFFFF, rdy_v;
   logic recv_val [0:15];
   logic recv_rdy [0:15];
   logic [31:0] recv_msg [0:15];
   logic [35:0] send_msg;
   int n_chk = 0, n_fail = 0;
   vec_t tbl [14];
   always #5 clk = ~clk;
   always_comb for (int i = 0; i < 16; i++) recv_val[i] = val_v[i];
   always_comb for (int i = 0; i < 16; i++) rdy_v[i] = recv_rdy[i];
   rr_tag_arbiter #(.nbits(32), .num_inputs(16)) dut (
      .clk(clk), .reset(reset), .recv_val(recv_val), .recv_rdy(recv_rdy),
      .recv_msg(recv_msg), .send_val(send_val), .send_rdy(send_rdy), .send_msg(send_msg)
   );
   function automatic logic [35:0] pkt(input logic [3:0] t);
      tag_pkt_t p;
      p.addr = t;
      p.payload = 32'hABC0_0000 + 32'(t);
      return p;
   endfunction
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask
   task automatic pulse_reset();
      @(negedge clk) reset = 1'b1;
      @(negedge clk) reset = 1'b0;
   endtask
   initial begin
      for (int i = 0; i < 16; i++) recv_msg[i] = 32'hABC0_0000 + 32'(i);
      tbl[0]  = '{16'h0060, 1'b1, 16'h0040, 1'b1, 4'h6};
      tbl[1]  = '{16'h0000, 1'b1, 16'h0000, 1'b0, 4'h0};
      tbl[2]  = '{16'h0000, 1'b0, 16'h0000, 1'b0, 4'h0};
      tbl[3]  = '{16'h4000, 1'b1, 16'h4000, 1'b1, 4'hE};
      tbl[4]  = '{16'h4008, 1'b1, 16'h0008, 1'b1, 4'h3};
      tbl[5]  = '{16'h4008, 1'b1, 16'h4000, 1'b1, 4'hE};
      tbl[6]  = '{16'h0204, 1'b0, 16'h0000, 1'b1, 4'hE};
      tbl[7]  = '{16'h0204, 1'b0, 16'h0000, 1'b1, 4'hE};
      tbl[8]  = '{16'h0204, 1'b0, 16'h0000, 1'b1, 4'hE};
      tbl[9]  = '{16'h0204, 1'b1, 16'h0004, 1'b1, 4'h2};
      tbl[10] = '{16'h0204, 1'b1, 16'h0200, 1'b1, 4'h9};
      tbl[11] = '{16'hFFFE, 1'b1, 16'h0400, 1'b1, 4'hA};
      tbl[12] = '{16'h0001, 1'b0, 16'h0000, 1'b1, 4'hA};
      tbl[13] = '{16'h0001, 1'b1, 16'h0001, 1'b1, 4'h0};
      @(negedge clk);
      chk("reset_rdy", 64'(rdy_v), 64'h0);
      chk("reset_sval", 64'(send_val), 64'h0);
      chk("reset_msg", 64'(send_msg), 64'h0);
      reset = 1'b0;
      val_v = 16'h0020;
      recv_msg[5] = 32'h0000_ABCD;
      #1 chk("single_rdy", 64'(rdy_v), 64'h0020);
      @(posedge clk) #1;
      chk("single_sval", 64'(send_val), 64'h1);
      chk("single_msg", 64'(send_msg), 64'h5_0000ABCD);
      recv_msg[5] = 32'hABC0_0005;
      for (int v = 0; v < 14; v++) begin
         @(negedge clk);
         val_v = tbl[v].val;
         send_rdy = tbl[v].srdy;
         #1 chk($sformatf("vec%0d_rdy", v), 64'(rdy_v), 64'(tbl[v].rdy));
         @(posedge clk) #1;
         chk($sformatf("vec%0d_sval", v), 64'(send_val), 64'(tbl[v].sval));
         if (tbl[v].sval) chk($sformatf("vec%0d_msg", v), 64'(send_msg), 64'(pkt(tbl[v].tag)));
      end
      pulse_reset();
      val_v = 16'h0080;
      send_rdy = 1'b0;
      @(posedge clk) #1;
      chk("pre_rst_msg", 64'(send_msg), 64'(pkt(4'h7)));
      #2 reset = 1'b1;
      #1;
      chk("midrst_sval", 64'(send_val), 64'h0);
      chk("midrst_msg", 64'(send_msg), 64'h0);
      chk("midrst_rdy", 64'(rdy_v), 64'h0);
      @(negedge clk);
      reset = 1'b0;
      val_v = 16'h1008;
      send_rdy = 1'b1;
      #1 chk("postrst_rdy", 64'(rdy_v), 64'h0008);
      @(posedge clk) #1;
      chk("postrst_msg", 64'(send_msg), 64'(pkt(4'h3)));
`ifndef RR_TAG_ARB_PRIO0_EN
      pulse_reset();
      val_v = 16'hFFFF;
      for (int k = 0; k < 17; k++) begin
         #1 chk($sformatf("all_rdy%0d", k), 64'(rdy_v), 64'(16'h1 << (k % 16)));
         @(posedge clk) #1;
         chk($sformatf("all_sval%0d", k), 64'(send_val), 64'h1);
         chk($sformatf("all_msg%0d", k), 64'(send_msg), 64'(pkt(4'(k % 16))));
         @(negedge clk);
      end
`else
      pulse_reset();
      val_v = 16'h0011;
      for (int k = 0; k < 5; k++) begin
         #1 chk($sformatf("prio_rdy%0d", k), 64'(rdy_v), 64'h0001);
         @(posedge clk) #1;
         chk($sformatf("prio_msg%0d", k), 64'(send_msg), 64'(pkt(4'h0)));
         @(negedge clk);
      end
      val_v = 16'h0010;
      #1 chk("prio_drop_rdy", 64'(rdy_v), 64'h0010);
      @(posedge clk) #1;
      chk("prio_drop_msg", 64'(send_msg), 64'(pkt(4'h4)));
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
